// File: rtl/wand_bus_arbiter_if.sv
// Signal bundle between the wired-AND bus arbiter and its requesters/line sampler.
// The slave modport is the arbiter's view; master is the requester/bus side.
interface wand_bus_arbiter_if #(
  parameter int unsigned N = 4
);
  logic [N-1:0] req;
  logic [N-1:0] done;
  logic [N-1:0] data_in;
  logic         bus_in;
  logic         clr_err;
  logic [N-1:0] gnt;
  logic         busy;
  logic         drv_low;
  logic         err_contention;
  logic         err_timeout;

  modport master (
    output req, done, data_in, bus_in, clr_err,
    input  gnt, busy, drv_low, err_contention, err_timeout
  );

  modport slave (
    input  req, done, data_in, bus_in, clr_err,
    output gnt, busy, drv_low, err_contention, err_timeout
  );
endinterface

// File: rtl/wand_bus_arbiter.sv
// Round-robin owner arbiter for a shared open-drain (wired-AND) line with
// forced-release timeout, a one-cycle turnaround and sticky contention/timeout flags.
module wand_bus_arbiter #(
  parameter int unsigned N   = 4,
  parameter int unsigned TMO = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  wand_bus_arbiter_if.slave    bus
);

  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned SW = IW + 1;
  localparam int unsigned HW = (TMO > 1) ? $clog2(TMO) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN  = 2'd1,
    TURN = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [IW-1:0] r_owner;
  logic [IW-1:0] w_owner_nxt;
  logic [IW-1:0] r_last_ptr;
  logic [IW-1:0] w_last_nxt;
  logic [IW-1:0] w_sel;
  logic [SW-1:0] w_idx;
  logic [HW-1:0] r_hold;
  logic [HW-1:0] w_hold_nxt;
  logic [N-1:0]  r_gnt;
  logic [N-1:0]  w_gnt_nxt;
  logic          r_busy;
  logic          r_drv_low;
  logic          w_drv_nxt;
  logic          r_err_contention;
  logic          r_err_timeout;
  logic          w_found;
  logic          w_own_done;
  logic          w_own_drop;
  logic          w_tmo_hit;
  logic          w_tmo_set;
  logic          w_cont_set;

  // Round-robin pick: first requester strictly after last_ptr, wrapping modulo N.
  always_comb begin
    w_found = 1'b0;
    w_sel   = r_last_ptr;
    w_idx   = '0;
    for (int unsigned i = 1; i <= N; i++) begin
      w_idx = SW'(r_last_ptr) + SW'(i);
      if (w_idx >= SW'(N)) begin
        w_idx = w_idx - SW'(N);
      end
      if (!w_found && bus.req[IW'(w_idx)]) begin
        w_found = 1'b1;
        w_sel   = IW'(w_idx);
      end
    end
  end

  assign w_own_done = bus.done[r_owner];
  assign w_own_drop = ~bus.req[r_owner];
  assign w_tmo_hit  = (r_hold == HW'(TMO - 1));
  assign w_cont_set = r_busy & ~r_drv_low & ~bus.bus_in;

  always_comb begin
    w_state_nxt = r_state;
    w_owner_nxt = r_owner;
    w_last_nxt  = r_last_ptr;
    w_hold_nxt  = r_hold;
    w_gnt_nxt   = '0;
    w_drv_nxt   = 1'b0;
    w_tmo_set   = 1'b0;
    case (r_state)
      IDLE: begin
        w_hold_nxt = '0;
        if (w_found) begin
          w_state_nxt = OWN;
          w_owner_nxt = w_sel;
          w_last_nxt  = w_sel;
          w_gnt_nxt   = N'(1) << w_sel;
          w_drv_nxt   = ~bus.data_in[w_sel];
        end
      end
      OWN: begin
        // done outranks a coincident timeout, so the flag is only set without done.
        if (w_own_done || w_own_drop || w_tmo_hit) begin
          w_state_nxt = TURN;
          w_hold_nxt  = '0;
          w_tmo_set   = w_tmo_hit & ~w_own_done;
        end else begin
          w_hold_nxt = r_hold + HW'(1);
          w_gnt_nxt  = N'(1) << r_owner;
          w_drv_nxt  = ~bus.data_in[r_owner];
        end
      end
      TURN: begin
        w_state_nxt = IDLE;
        w_hold_nxt  = '0;
      end
      default: begin
        w_state_nxt = IDLE;
        w_hold_nxt  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // last_ptr resets to N-1 so requester 0 wins the first arbitration.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_owner          <= '0;
      r_last_ptr       <= IW'(N - 1);
      r_hold           <= '0;
      r_gnt            <= '0;
      r_busy           <= 1'b0;
      r_drv_low        <= 1'b0;
      r_err_contention <= 1'b0;
      r_err_timeout    <= 1'b0;
    end else begin
      r_owner    <= w_owner_nxt;
      r_last_ptr <= w_last_nxt;
      r_hold     <= w_hold_nxt;
      r_gnt      <= w_gnt_nxt;
      r_busy     <= |w_gnt_nxt;
      r_drv_low  <= w_drv_nxt;
      if (w_cont_set) begin
        r_err_contention <= 1'b1;
      end else if (bus.clr_err) begin
        r_err_contention <= 1'b0;
      end
      if (w_tmo_set) begin
        r_err_timeout <= 1'b1;
      end else if (bus.clr_err) begin
        r_err_timeout <= 1'b0;
      end
    end
  end

  assign bus.gnt            = r_gnt;
  assign bus.busy           = r_busy;
  assign bus.drv_low        = r_drv_low;
  assign bus.err_contention = r_err_contention;
  assign bus.err_timeout    = r_err_timeout;

endmodule

// File: tb/tb_wand_bus_arbiter.sv
// Self-checking bench for wand_bus_arbiter: directed scenarios plus randomized
// traffic, all compared against a cycle-level ownership model.
module tb_wand_bus_arbiter;

  localparam int unsigned N   = 4;
  localparam int unsigned TMO = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  wand_bus_arbiter_if #(.N(N)) bus ();

  wand_bus_arbiter #(.N(N), .TMO(TMO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: who owns the line, how many cycles it has shown gnt, turnaround pending.
  int m_owner;
  int m_cycles;
  int m_last;
  bit m_turn;
  bit m_drv;
  bit m_ec;
  bit m_et;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [N-1:0] m_gnt();
    logic [N-1:0] g;
    g = '0;
    if (m_owner >= 0) g[m_owner] = 1'b1;
    return g;
  endfunction

  task automatic model_reset();
    m_owner  = -1;
    m_cycles = 0;
    m_last   = int'(N) - 1;
    m_turn   = 1'b0;
    m_drv    = 1'b0;
    m_ec     = 1'b0;
    m_et     = 1'b0;
  endtask

  task automatic model_edge();
    bit ec_set;
    bit et_set;
    int idx;
    ec_set = (m_owner >= 0) && !m_drv && !bus.bus_in;
    et_set = 1'b0;
    if (m_owner >= 0) begin
      if (bus.done[m_owner] || !bus.req[m_owner] || m_cycles == int'(TMO)) begin
        et_set  = (m_cycles == int'(TMO)) && !bus.done[m_owner];
        m_owner = -1;
        m_turn  = 1'b1;
        m_drv   = 1'b0;
      end else begin
        m_cycles++;
        m_drv = !bus.data_in[m_owner];
      end
    end else if (m_turn) begin
      m_turn = 1'b0;
    end else begin
      for (int k = 1; k <= int'(N); k++) begin
        idx = (m_last + k) % int'(N);
        if (m_owner < 0 && bus.req[idx]) begin
          m_owner  = idx;
          m_last   = idx;
          m_cycles = 1;
          m_drv    = !bus.data_in[idx];
        end
      end
    end
    m_ec = ec_set ? 1'b1 : (bus.clr_err ? 1'b0 : m_ec);
    m_et = et_set ? 1'b1 : (bus.clr_err ? 1'b0 : m_et);
  endtask

  task automatic compare_all(input string ph);
    check({ph, "_gnt"},     32'(bus.gnt),            32'(m_gnt()));
    check({ph, "_busy"},    32'(bus.busy),           32'(m_owner >= 0));
    check({ph, "_drv_low"}, 32'(bus.drv_low),        32'(m_drv));
    check({ph, "_err_c"},   32'(bus.err_contention), 32'(m_ec));
    check({ph, "_err_t"},   32'(bus.err_timeout),    32'(m_et));
    check({ph, "_onehot"},  32'($countones(bus.gnt) <= 1), 32'(1));
  endtask

  // Called at a negedge with inputs already driven; returns at the next negedge.
  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    compare_all("cyc");
    @(negedge clk);
  endtask

  task automatic drive_idle();
    bus.req     = '0;
    bus.done    = '0;
    bus.data_in = '0;
    bus.bus_in  = 1'b1;
    bus.clr_err = 1'b0;
  endtask

  // Asynchronous reset pulse taken mid-cycle while clk is low.
  task automatic async_reset();
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    compare_all("rst");
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  int c;
  int z;
  int exp_order [5] = '{0, 1, 2, 3, 0};

  initial begin
    drive_idle();
    model_reset();
    #1;
    compare_all("por");
    @(negedge clk);
    rst_n = 1'b1;

    // Requester 0 first after reset, then round-robin to 2.
    bus.req = 4'b0101;
    tick();
    check("r036_first", 32'(bus.gnt), 32'(4'b0001));
    bus.done = 4'b0001;
    tick();
    bus.done = '0;
    check("r036_turn", 32'(bus.gnt), 32'(0));
    tick();
    check("r036_idle", 32'(bus.gnt), 32'(0));
    tick();
    check("r036_second", 32'(bus.gnt), 32'(4'b0100));

    // Full rotation with done after three owned cycles.
    drive_idle();
    async_reset();
    bus.req = 4'b1111;
    tick();
    for (int k = 0; k < 5; k++) begin
      check("r037_order", 32'(bus.gnt), 32'(4'b0001 << exp_order[k]));
      if (k < 4) begin
        tick();
        tick();
        bus.done = bus.gnt;
        tick();
        bus.done = '0;
        z = 0;
        while (bus.gnt == '0 && z < 8) begin
          z++;
          tick();
        end
        check("r037_gap", 32'(z), 32'(2));
      end
    end

    // Timeout: owner 2 never pulses done.
    drive_idle();
    async_reset();
    bus.req = 4'b0100;
    tick();
    c = 0;
    while (bus.gnt == 4'b0100 && c < 40) begin
      c++;
      tick();
    end
    check("r038_hold", 32'(c), 32'(TMO));
    check("r038_err_t", 32'(bus.err_timeout), 32'(1));
    repeat (3) tick();
    check("r038_sticky", 32'(bus.err_timeout), 32'(1));
    bus.clr_err = 1'b1;
    tick();
    bus.clr_err = 1'b0;
    check("r038_clr", 32'(bus.err_timeout), 32'(0));

    // clr_err coinciding with the timeout exit loses to the set.
    c = 0;
    while (m_cycles < int'(TMO) && c < 40) begin
      c++;
      tick();
    end
    bus.clr_err = 1'b1;
    tick();
    bus.clr_err = 1'b0;
    check("r041_err_t", 32'(bus.err_timeout), 32'(1));
    check("r041_gnt", 32'(bus.gnt), 32'(0));

    // Contention: line low while owner released it vs. while owner pulls it.
    drive_idle();
    async_reset();
    bus.req     = 4'b0001;
    bus.data_in = 4'b0001;
    tick();
    check("r039_drv0", 32'(bus.drv_low), 32'(0));
    bus.bus_in = 1'b0;
    tick();
    check("r039_err_c", 32'(bus.err_contention), 32'(1));
    bus.bus_in  = 1'b1;
    bus.clr_err = 1'b1;
    tick();
    bus.clr_err = 1'b0;
    check("r039_clr", 32'(bus.err_contention), 32'(0));
    bus.data_in = 4'b0000;
    tick();
    check("r039_drv1", 32'(bus.drv_low), 32'(1));
    bus.bus_in = 1'b0;
    tick();
    tick();
    check("r039_no_err", 32'(bus.err_contention), 32'(0));

    // Async reset mid-ownership with the line pulled low and an error pending.
    bus.data_in = 4'b0001;
    bus.bus_in  = 1'b1;
    tick();
    bus.bus_in = 1'b0;
    tick();
    bus.data_in = 4'b0000;
    bus.bus_in  = 1'b1;
    tick();
    check("r040_pre_drv", 32'(bus.drv_low), 32'(1));
    check("r040_pre_err", 32'(bus.err_contention), 32'(1));
    bus.req = 4'b1111;
    async_reset();
    check("r040_drv", 32'(bus.drv_low), 32'(0));
    check("r040_err", 32'(bus.err_contention), 32'(0));
    tick();
    check("r040_next", 32'(bus.gnt), 32'(4'b0001));

    // Randomized traffic with occasional asynchronous resets.
    for (int n = 0; n < 3000; n++) begin
      for (int b = 0; b < int'(N); b++) begin
        if ($urandom_range(0, 7) == 0) bus.req[b] = ~bus.req[b];
      end
      bus.done    = ($urandom_range(0, 5) == 0) ? N'($urandom) : '0;
      bus.data_in = N'($urandom);
      bus.bus_in  = m_drv ? 1'b0 : ($urandom_range(0, 15) != 0);
      bus.clr_err = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 499) == 0) begin
        async_reset();
      end else begin
        tick();
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
